// File: rtl/lsu.sv
// lsu -- load/store unit between a core request port and a simple memory port.
//
// Accepts one request at a time, turns it into a single word-aligned memory
// access with byte-lane mask, and returns a one-cycle response with the
// loaded data extended to 32 bits, or an error.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   req_valid/ready     core request handshake (ready only while idle)
//   req_write           1 = store, 0 = load
//   req_unsigned        zero-extend load result
//   req_size            00 byte, 01 half, 10 word, 11 reserved (error)
//   req_addr, req_wdata byte address, right-justified store data
//   resp_valid          one-cycle response strobe
//   resp_rdata          extended load data (0 for stores and errors)
//   resp_error          access failed (reserved size, misalign trap, timeout)
//   mem_addr/mask       word-aligned address and byte-lane enables
//   mem_enable, mem_cmd access strobe and direction (MEM_CMD_READ/WRITE)
//   mem_write_data      store data replicated across lanes
//   mem_load_data       read data from memory
//   mem_valid           read data valid
//
// Configuration
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses return
//                         an error without touching memory; otherwise the low
//                         address bits are cleared and the aligned access runs.
module lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic        req_unsigned,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_mask,
   output logic        mem_enable,
   output logic        mem_cmd,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_load_data,
   input  logic        mem_valid
);

   localparam logic MEM_CMD_READ  = 1'b0;
   localparam logic MEM_CMD_WRITE = 1'b1;

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic        ready_q;
   logic        write_q, write_d;
   logic        unsigned_q, unsigned_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        half_mis, word_mis, fault;
   logic [31:0] addr_adj;
   logic [31:0] ld_shift, ld_ext;

   // Misalignment handling on the incoming request
   always_comb begin
      half_mis = (req_size == 2'b01) && req_addr[0];
      word_mis = (req_size == 2'b10) && (req_addr[1:0] != 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
      fault    = half_mis | word_mis;
      addr_adj = req_addr;
`else
      fault    = 1'b0;
      addr_adj = req_addr;
      if (word_mis)      addr_adj = {req_addr[31:2], 2'b00};
      else if (half_mis) addr_adj = {req_addr[31:1], 1'b0};
`endif
   end

   // Load data: align selected lane(s) to bit 0, then extend
   always_comb begin
      ld_shift = mem_load_data >> {addr_q[1:0], 3'b000};
      case (size_q)
         2'b00:   ld_ext = unsigned_q ? {24'h0, ld_shift[7:0]}
                                      : {{24{ld_shift[7]}}, ld_shift[7:0]};
         2'b01:   ld_ext = unsigned_q ? {16'h0, ld_shift[15:0]}
                                      : {{16{ld_shift[15]}}, ld_shift[15:0]};
         default: ld_ext = ld_shift;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         ready_q    <= 1'b0;
         write_q    <= 1'b0;
         unsigned_q <= 1'b0;
         size_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_q    <= 1'b1;
         write_q    <= write_d;
         unsigned_q <= unsigned_d;
         size_q     <= size_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
      end
   end

   // ready_q keeps req_ready low during reset and for the first cycle after it
   assign req_ready = (state_q == S_IDLE) && ready_q;

   always_comb begin
      state_d    = state_q;
      write_d    = write_q;
      unsigned_d = unsigned_q;
      size_d     = size_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               write_d    = req_write;
               unsigned_d = req_unsigned;
               size_d     = req_size;
               addr_d     = addr_adj;
               wdata_d    = req_wdata;
               cnt_d      = '0;
               rdata_d    = '0;
               err_d      = 1'b0;
               if ((req_size == 2'b11) || fault) begin
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else if (req_write) begin
                  state_d = S_WRITE;
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_WRITE: state_d = S_RESP;
         S_READ: begin
            if (mem_valid) begin
               rdata_d = ld_ext;
               state_d = S_RESP;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_enable     = (state_q == S_READ) || (state_q == S_WRITE);
      mem_addr       = '0;
      mem_mask       = '0;
      mem_cmd        = MEM_CMD_READ;
      mem_write_data = '0;
      if (mem_enable) begin
         mem_addr = {addr_q[31:2], 2'b00};
         mem_cmd  = (state_q == S_WRITE) ? MEM_CMD_WRITE : MEM_CMD_READ;
         case (size_q)
            2'b00: begin
               mem_mask       = 4'b0001 << addr_q[1:0];
               mem_write_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
               mem_mask       = 4'b0011 << {addr_q[1], 1'b0};
               mem_write_data = {2{wdata_q[15:0]}};
            end
            default: begin
               mem_mask       = 4'b1111;
               mem_write_data = wdata_q;
            end
         endcase
      end
   end

   assign resp_valid = (state_q == S_RESP);
   assign resp_rdata = resp_valid ? rdata_q : '0;
   assign resp_error = resp_valid & err_q;

endmodule
